// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory responder: FSM encoding,
// canned instruction words and the address range check.
package imem_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [15:0] InstrNop  = 16'h0800;
    localparam logic [15:0] InstrHalt = 16'h0000;

    // True when a byte address lies beyond 2^depth_log2 16-bit words.
    function automatic logic addr_out_of_range(input logic [15:0] addr,
                                               input int unsigned depth_log2);
        logic [31:0] wide;
        wide = {16'd0, addr};
        return (wide >> (depth_log2 + 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage for the responder: one synchronous write port and one
// combinational read port, so a same-edge write is not seen by the reader.
module imem_array #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [15:0]           wr_data_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [15:0]           rd_data_o
);

    logic [15:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with flush, misalignment/range
// errors and a preload write port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [15:0] rsp_instr,
    output logic [15:0] rsp_addr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam logic [1:0] CntInit = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rsp_instr_q, rsp_instr_d;
    logic [15:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept, enter_resp, rd_err;
    logic [15:0] rd_addr, rd_data;
    logic        load_we;

    assign req_ready = (state_q == StIdle) || ((state_q == StResp) && !flush);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == StResp) && !flush;

    // With LATENCY 1 the read happens on the accepting edge, before capture.
    assign rd_addr = (state_q == StWait) ? addr_q : req_addr;
    assign rd_err  = rd_addr[0] || addr_out_of_range(rd_addr, DEPTH_LOG2);
    assign load_we = load_en && !addr_out_of_range(load_addr, DEPTH_LOG2);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end else if (cnt_q == 2'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
                if (accept) begin
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rsp_instr_d = rsp_instr_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_addr_d  = rd_addr;
            rsp_err_d   = rd_err;
            rsp_instr_d = rd_err ? InstrNop : rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            addr_q      <= 16'd0;
            rsp_instr_q <= InstrHalt;
            rsp_addr_q  <= 16'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i     (clk),
        .wr_en_i   (load_we),
        .wr_idx_i  (load_addr[DEPTH_LOG2:1]),
        .wr_data_i (load_data),
        .rd_idx_i  (rd_addr[DEPTH_LOG2:1]),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic against a
// transaction-level model (pending request with due cycle, word array).
module tb_imem_responder;

    localparam int unsigned LAT = 2;
    localparam int unsigned DL2 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_err;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;

    imem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state
    logic [15:0] mem_m [2**DL2];
    logic        pend = 1'b0;
    int          due = 0;
    logic [15:0] pend_addr = 16'd0;
    logic [15:0] exp_instr = 16'd0;
    logic [15:0] exp_addr = 16'd0;
    logic        exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic model_err(input logic [15:0] a);
        return a[0] || ((a >> (DL2 + 1)) != 16'd0);
    endfunction

    task automatic step(input logic rv, input logic [15:0] ra, input logic fl,
                        input logic le, input logic [15:0] la, input logic [15:0] ld);
        logic        resp_now;
        logic        exp_ready;
        logic        exp_valid;
        logic        acc;
        logic [15:0] widx;
        @(negedge clk);
        req_valid = rv;
        req_addr  = ra;
        flush     = fl;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        #1;
        resp_now  = pend && (due == cyc);
        exp_ready = !pend || (resp_now && !fl);
        exp_valid = resp_now && !fl;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check_eq("rsp_instr", 32'(rsp_instr), 32'(exp_instr));
        check_eq("rsp_addr", 32'(rsp_addr), 32'(exp_addr));
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        acc = rv && exp_ready;
        if (resp_now || fl) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            due       = cyc + int'(LAT);
            pend_addr = ra;
        end
        // Output registers capture on the edge before the response cycle.
        if (pend && (due == cyc + 1)) begin
            exp_addr  = pend_addr;
            exp_err   = model_err(pend_addr);
            widx      = (pend_addr >> 1) & 16'(2**DL2 - 1);
            exp_instr = exp_err ? 16'h0800 : mem_m[widx];
        end
        if (le && ((la >> (DL2 + 1)) == 16'd0)) begin
            widx = (la >> 1) & 16'(2**DL2 - 1);
            mem_m[widx] = ld;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic req(input logic [15:0] a);
        step(1'b1, a, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, 16'd0, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        logic        rv, fl, le;
        logic [15:0] ra, la, ld;
        int          sel;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #12;
        check_eq("reset_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_instr", 32'(rsp_instr), 32'd0);
        check_eq("reset_addr", 32'(rsp_addr), 32'd0);
        check_eq("reset_err", 32'(rsp_err), 32'd0);
        check_eq("reset_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 2**DL2; i++) load(16'(i * 2), 16'($urandom));

        // Single read of a known word
        load(16'h0006, 16'hA5C3);
        req(16'h0006);
        idle(3);

        // Back-to-back with req_valid held
        req(16'h0000); req(16'h0002); req(16'h0002); req(16'h0004); req(16'h0004);
        idle(3);

        // Misaligned and out-of-range
        req(16'h0003); idle(3);
        req(16'h0400); idle(3);

        // Flush drops the in-flight request
        req(16'h0000);
        step(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 16'd0);
        req(16'h0010);
        idle(4);

        // Flush in idle with a concurrent request
        step(1'b1, 16'h0020, 1'b1, 1'b0, 16'd0, 16'd0);
        idle(3);

        // Same-edge load is not visible to the read
        load(16'h000A, 16'h5555);
        req(16'h000A);
        load(16'h000A, 16'h1234);
        idle(2);
        req(16'h000A);
        idle(3);

        // Asynchronous reset while waiting
        req(16'h0006);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0; load_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("async_rst_instr", 32'(rsp_instr), 32'd0);
        check_eq("async_rst_addr", 32'(rsp_addr), 32'd0);
        check_eq("async_rst_err", 32'(rsp_err), 32'd0);
        pend = 1'b0; exp_instr = '0; exp_addr = '0; exp_err = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        cyc++;
        idle(4);

        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 9) < 7);
            sel = int'($urandom_range(0, 9));
            ra  = 16'($urandom_range(0, 2**DL2 - 1)) << 1;
            if (sel == 7) ra = ra | 16'h0001;
            else if (sel == 8) ra = 16'($urandom) | 16'h0200;
            else if (sel == 9) ra = 16'($urandom);
            fl = ($urandom_range(0, 9) == 0);
            le = ($urandom_range(0, 4) == 0);
            la = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
            ld = 16'($urandom);
            step(rv, ra, fl, le, la, ld);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
